sensor_debounce_filter: RTL and testbench

SENSOR_DEBOUNCE_FILTER -- requirements
Module: sensor_debounce_filter

---
 rtl/sensor_debounce_filter.sv | 111 +++++++++++
 tb/tb_sensor_debounce_filter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sensor_debounce_filter.sv
// Three-channel debounce filter for distance sensors: 2-flop synchronizer,
// then a per-channel run-length counter with an IDLE/ACTIVE state machine.
module sensor_debounce_filter #(
  parameter int unsigned ON_CNT  = 4,
  parameter int unsigned OFF_CNT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [2:0] sensor_raw,
  output logic [2:0] sensor_clean,
  output logic [2:0] change_pulse,
  output logic       any_active
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [3:0] ON_LAST  = 4'(ON_CNT - 1);
  localparam logic [3:0] OFF_LAST = 4'(OFF_CNT - 1);

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;

  // The synchronizer also freezes while disabled so a resume starts from
  // exactly the samples that were in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else if (ena) begin
      sync1_q <= sensor_raw;
      sync2_q <= sync1_q;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      state_e     state_q;
      state_e     state_d;
      logic [3:0] cnt_q;
      logic [3:0] cnt_d;
      logic       pulse_q;
      logic       clean;

      // State register; the pulse is cleared on reset so an aborted
      // ACTIVE state never produces a strobe.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
          pulse_q <= 1'b0;
        end else begin
          if (ena) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
          end
          pulse_q <= ena && (state_d != state_q);
        end
      end

      // Next state: count consecutive samples opposite to the current level.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
          IDLE: begin
            if (sync2_q[gi]) begin
              if (cnt_q == ON_LAST) begin
                state_d = ACTIVE;
                cnt_d   = 4'd0;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else begin
              cnt_d = 4'd0;
            end
          end
          ACTIVE: begin
            if (!sync2_q[gi]) begin
              if (cnt_q == OFF_LAST) begin
                state_d = IDLE;
                cnt_d   = 4'd0;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else begin
              cnt_d = 4'd0;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end

      always_comb begin
        clean = (state_q == ACTIVE);
      end

      assign sensor_clean[gi] = clean;
      assign change_pulse[gi] = pulse_q;
    end
  endgenerate

  assign any_active = |sensor_clean;

endmodule

// File: tb/tb_sensor_debounce_filter.sv
// Bench for sensor_debounce_filter: constant vector table, hand-written
// corner sequences and randomized traffic against a run-length reference.
module tb_sensor_debounce_filter;

  localparam int ON_CNT  = 4;
  localparam int OFF_CNT = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] sensor_raw;
  logic [2:0] sensor_clean;
  logic [2:0] change_pulse;
  logic       any_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference: two-sample delay line, then per channel the number of
  // consecutive samples disagreeing with the clean level.
  bit [2:0] m_p1, m_s, m_clean, m_pulse;
  int       m_run[3];

  sensor_debounce_filter #(.ON_CNT(ON_CNT), .OFF_CNT(OFF_CNT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sensor_raw  (sensor_raw),
    .sensor_clean(sensor_clean),
    .change_pulse(change_pulse),
    .any_active  (any_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got any/clean/pulse=%b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input bit [2:0] raw, input bit en, input bit rn);
    if (!rn) begin
      m_p1 = '0; m_s = '0; m_clean = '0; m_pulse = '0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else if (en) begin
      for (int c = 0; c < 3; c++) begin
        int thr;
        thr = m_clean[c] ? OFF_CNT : ON_CNT;
        m_run[c]   = (m_s[c] != m_clean[c]) ? m_run[c] + 1 : 0;
        m_pulse[c] = 1'b0;
        if (m_run[c] == thr) begin
          m_clean[c] = ~m_clean[c];
          m_run[c]   = 0;
          m_pulse[c] = 1'b1;
        end
      end
      m_s  = m_p1;
      m_p1 = raw;
    end else begin
      m_pulse = '0;
    end
  endtask

  task automatic drive_edge(input logic [2:0] raw, input logic en, input logic rn);
    sensor_raw = raw;
    ena        = en;
    rst_n      = rn;
    @(posedge clk);
    model_edge(raw, en, rn);
    #1;
    cyc++;
    $display("cyc=%0d raw=%b ena=%b rst_n=%b clean=%b pulse=%b any=%b", cyc, raw, en, rn,
             sensor_clean, change_pulse, any_active);
    check("model", {any_active, sensor_clean, change_pulse}, {|m_clean, m_clean, m_pulse});
  endtask

  task automatic wait_rise(input logic [2:0] raw, input logic [2:0] mask, input int exp_n,
                           input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      drive_edge(raw, 1'b1, 1'b1);
      n++;
      if ((sensor_clean & mask) == mask) seen = 1;
    end
    checks++;
    if (!seen || n != exp_n) begin
      errors++;
      $display("FAIL %s: rise after %0d edges (seen=%0d), expected %0d", name, n, seen, exp_n);
    end
  endtask

  typedef struct {
    logic [2:0] raw;
    logic       en;
    logic       rn;
    logic [2:0] clean;
    logic [2:0] pulse;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int pulses;
    logic [2:0] cur;

    sensor_raw = 3'b000;
    ena        = 1'b1;
    rst_n      = 1'b0;

    // Reset, then raw=001 stable from the first post-reset edge.
    tbl[0]  = '{3'b000, 1'b1, 1'b0, 3'b000, 3'b000};
    tbl[1]  = '{3'b001, 1'b0, 1'b0, 3'b000, 3'b000};
    tbl[2]  = '{3'b001, 1'b1, 1'b1, 3'b000, 3'b000};
    tbl[3]  = '{3'b001, 1'b1, 1'b1, 3'b000, 3'b000};
    tbl[4]  = '{3'b001, 1'b1, 1'b1, 3'b000, 3'b000};
    tbl[5]  = '{3'b001, 1'b1, 1'b1, 3'b000, 3'b000};
    tbl[6]  = '{3'b001, 1'b1, 1'b1, 3'b000, 3'b000};
    tbl[7]  = '{3'b001, 1'b1, 1'b1, 3'b001, 3'b001};
    tbl[8]  = '{3'b001, 1'b1, 1'b1, 3'b001, 3'b000};
    tbl[9]  = '{3'b000, 1'b0, 1'b1, 3'b001, 3'b000};
    tbl[10] = '{3'b001, 1'b1, 1'b1, 3'b001, 3'b000};
    for (int i = 0; i < 11; i++) begin
      drive_edge(tbl[i].raw, tbl[i].en, tbl[i].rn);
      check("table", {any_active, sensor_clean, change_pulse},
            {|tbl[i].clean, tbl[i].clean, tbl[i].pulse});
    end

    // Channel 0 active: 7 lows, one high glitch, 8 lows.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive_edge((i == 7) ? 3'b001 : 3'b000, 1'b1, 1'b1);
      pulses += int'(change_pulse[0]);
      if (i >= 8 && i <= 16) check("glitch_hold", {6'b0, sensor_clean[0]}, 7'b1);
      if (i == 17) check("glitch_fall", {5'b0, sensor_clean[0], change_pulse[0]}, 7'b01);
    end
    check("glitch_pulses", 7'(pulses), 7'd1);

    // All three channels rise together.
    wait_rise(3'b111, 3'b111, ON_CNT + 2, "simul_rise");
    check("simul_pulse", {any_active, sensor_clean, change_pulse}, 7'b1111111);
    drive_edge(3'b111, 1'b1, 1'b1);
    check("simul_pulse_end", {any_active, sensor_clean, change_pulse}, 7'b1111000);

    // Reset while ACTIVE aborts without a strobe; re-assert takes ON_CNT+2 edges.
    drive_edge(3'b111, 1'b1, 1'b0);
    check("reset_active", {any_active, sensor_clean, change_pulse}, 7'b0000000);
    wait_rise(3'b111, 3'b111, ON_CNT + 2, "reset_reassert");

    // Short high run on channel 1 must not assert; count restarts.
    drive_edge(3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_edge(3'b010, 1'b1, 1'b1);
    drive_edge(3'b000, 1'b1, 1'b1);
    check("short_run", {6'b0, sensor_clean[1]}, 7'b0);
    wait_rise(3'b010, 3'b010, ON_CNT + 2, "restart_rise");

    // Freeze mid-count while raw toggles, then resume from the held count.
    drive_edge(3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_edge(3'b100, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive_edge(3'($urandom_range(0, 7)), 1'b0, 1'b1);
      check("freeze", {any_active, sensor_clean, change_pulse}, 7'b0000000);
    end
    wait_rise(3'b100, 3'b100, 3, "resume_rise");

    // Randomized traffic with slowly flipping levels.
    cur = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 5) == 0) cur[c] = ~cur[c];
      drive_edge(cur, ($urandom_range(0, 7) != 0), ($urandom_range(0, 199) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
